spi_mult_master: RTL and testbench
==================================

// Module: spi_mult_master
// PURPOSE
//   SPI initiator for the SPI multiplier peripheral. Serialises operands A and B
//   on MOSI, waits a fixed turnaround, then clocks the product back on MISO.
//   It generates SCLK and CS from the system clock. It sits between a host
//   (START/A/B in, PRODUCT/DONE out) and the peripheral's SPI pins.
// PARAMETERS
//   OP_WIDTH    4   width of each operand; MSB first on MOSI
//   RES_WIDTH   8   product width returned on MISO; must equal 2*OP_WIDTH
//   HALF_PERIOD 10  CLK cycles per SCLK half period; minimum 2
//   TURNAROUND  8   full SCLK periods between the last MOSI bit and the first MISO bit
// PORTS
//   CLK      in   1          system clock; all logic on posedge
//   RST      in   1          synchronous, active-high reset
//   START    in   1          request a transaction; sampled only in IDLE
//   A        in   OP_WIDTH   operand A; latched when START is accepted
//   B        in   OP_WIDTH   operand B; latched when START is accepted
//   BUSY     out  1          high from START accept through the DONE cycle
//   DONE     out  1          one-CLK pulse; PRODUCT is valid from this cycle on
//   PRODUCT  out  RES_WIDTH  last received result; held until the next DONE
//   SCLK     out  1          SPI clock; idles low
//   CS       out  1          chip select, ACTIVE-HIGH; high for the whole transaction
//   MOSI     out  1          serial data out; idles 0
//   MISO     in   1          serial data in
// BEHAVIOUR
//   Reset: BUSY=0, DONE=0, PRODUCT=0, SCLK=0, CS=0, MOSI=0, state=IDLE, counters=0.
//     RST mid-transaction aborts on that edge: no DONE; PRODUCT is cleared.
//   States:
//     IDLE -> SEND on START (same edge as the accept).
//     SEND -> WAIT after 2*OP_WIDTH SCLK rising edges.
//     WAIT -> RECV after TURNAROUND rising edges.
//     RECV -> FIN after RES_WIDTH rising edges.
//     FIN -> IDLE after one CLK.
//   Accept edge: latch {A,B} into the shift register; CS=1, BUSY=1, MOSI=A[MSB], SCLK=0.
//     Start the half-period counter.
//   SCLK: toggles every HALF_PERIOD CLK cycles while state is SEND, WAIT or RECV.
//     A "rise edge" is the CLK edge on which SCLK goes 0->1; a "fall edge" goes 1->0.
//   SEND: on each fall edge, MOSI shifts to the next bit (A MSB..LSB, then B MSB..LSB).
//     Each bit is stable a full half period before the peripheral samples it on SCLK rise.
//   WAIT: MOSI=0, SCLK keeps running, MISO ignored.
//   RECV: on each rise edge, MISO shifts into the receive register LSB-side, MSB first.
//     MOSI=0.
//   FIN: SCLK=0, CS=0, MOSI=0, PRODUCT<=receive register, DONE=1 for this cycle only.
//     BUSY drops on the next edge.
//   Latency: DONE is high exactly 2*HALF_PERIOD*(2*OP_WIDTH+TURNAROUND+RES_WIDTH)
//     CLK cycles after the accept edge (480 with defaults).
//   START while BUSY: ignored, not queued. START in the FIN cycle: ignored.
//     START held high in IDLE starts a new transaction on the first IDLE edge.
//   A/B changes after the accept edge have no effect on the transaction in flight.
//   Counter wrap: bit and half-period counters reset to 0 on every state transition.
//     No overflow is possible for legal parameters.
// CONFIGURATION
//   SPI_MASTER_CHECK_EN defined:
//     - Adds output MISMATCH (1 bit, reset 0).
//     - Computes A*B (RES_WIDTH bits, unsigned) from the latched operands.
//     - In the FIN cycle, MISMATCH <= (received != expected); held until the next FIN or RST.
//   SPI_MASTER_CHECK_EN undefined: no MISMATCH port, no multiplier logic; all
//     other behaviour is identical.
// TESTING  (bench pairs the block with a behavioural SPI multiplier slave unless noted)
//   1. A=4'h1, B=4'h6, START pulse
//      -> MOSI bits on SCLK rises = 0,0,0,1,0,1,1,0; DONE after 480 CLK; PRODUCT=8'h06.
//   2. A=4'hF, B=4'hF -> PRODUCT=8'hE1; CS high continuously from accept to FIN;
//      SCLK low whenever CS is low.
//   3. START pulsed again 100 CLK into a transaction
//      -> ignored; exactly one DONE; BUSY stays 1 until FIN+1.
//   4. RST asserted mid-SEND -> next edge SCLK=0, CS=0, MOSI=0, BUSY=0, PRODUCT=0; no DONE.
//      A new START then completes normally.
//   5. No slave, MISO tied 1, A=4'h0, B=4'h9 -> PRODUCT=8'hFF;
//      with SPI_MASTER_CHECK_EN MISMATCH=1. Rerun with the slave -> PRODUCT=8'h00, MISMATCH=0.
//   6. START held high for 2 transactions -> back-to-back runs with exactly 1 IDLE cycle
//      between FIN and the next accept; both PRODUCTs correct.

Source files
------------

// File: rtl/spi_mult_master.sv
// SPI initiator for the SPI multiplier peripheral: sends A,B on MOSI, reads the product on MISO.
// Optional result self-check enabled by `define SPI_MASTER_CHECK_EN (adds MISMATCH output).
module spi_mult_master #(
   parameter int OP_WIDTH    = 4,
   parameter int RES_WIDTH   = 8,
   parameter int HALF_PERIOD = 10,
   parameter int TURNAROUND  = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic [OP_WIDTH-1:0]  A,
   input  logic [OP_WIDTH-1:0]  B,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [RES_WIDTH-1:0] PRODUCT,
   output logic                 SCLK,
   output logic                 CS,
   output logic                 MOSI,
`ifdef SPI_MASTER_CHECK_EN
   output logic                 MISMATCH,
`endif
   input  logic                 MISO
);

   localparam int SEND_N = 2 * OP_WIDTH;
   localparam int MAX_A  = (SEND_N > TURNAROUND) ? SEND_N : TURNAROUND;
   localparam int MAXN   = (MAX_A > RES_WIDTH) ? MAX_A : RES_WIDTH;
   localparam int BW     = $clog2(MAXN + 1);
   localparam int HW     = $clog2(HALF_PERIOD);
   localparam int SW     = SEND_N - 1;

   localparam logic [HW-1:0] HP_LAST = HW'(HALF_PERIOD - 1);
   localparam logic [BW-1:0] N_SEND  = BW'(SEND_N);
   localparam logic [BW-1:0] N_WAIT  = BW'(TURNAROUND);
   localparam logic [BW-1:0] N_RECV  = BW'(RES_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_RECV,
      S_FIN
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [HW-1:0]        r_hcnt;
   logic [BW-1:0]        r_bcnt;
   logic [SW-1:0]        r_sh;
   logic [RES_WIDTH-1:0] r_rx;
   logic [RES_WIDTH-1:0] r_product;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_sclk;
   logic                 r_cs;
   logic                 r_mosi;
   logic                 w_active;
   logic                 w_tick;
   logic                 w_rise;
   logic                 w_fall;
   logic                 w_end;
   logic [BW-1:0]        w_lim;

   assign w_active = (r_state == S_SEND) || (r_state == S_WAIT) ||
                     (r_state == S_RECV);
   assign w_tick   = (r_hcnt == HP_LAST);
   assign w_rise   = w_active && w_tick && !r_sclk;
   assign w_fall   = w_active && w_tick && r_sclk;
   assign w_lim    = (r_state == S_SEND) ? N_SEND :
                     (r_state == S_WAIT) ? N_WAIT : N_RECV;
   // A phase ends on the fall that completes its last full SCLK period
   assign w_end    = w_fall && (r_bcnt == w_lim);

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (START) w_next = S_SEND;
         S_SEND:  if (w_end) w_next = S_WAIT;
         S_WAIT:  if (w_end) w_next = S_RECV;
         S_RECV:  if (w_end) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

`ifdef SPI_MASTER_CHECK_EN
   logic [OP_WIDTH-1:0]  r_a;
   logic [OP_WIDTH-1:0]  r_b;
   logic                 r_mismatch;
   logic [RES_WIDTH-1:0] w_expect;

   assign w_expect = RES_WIDTH'(r_a) * RES_WIDTH'(r_b);
   assign MISMATCH = r_mismatch;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_a        <= '0;
         r_b        <= '0;
         r_mismatch <= 1'b0;
      end else begin
         if (r_state == S_IDLE && START) begin
            r_a <= A;
            r_b <= B;
         end
         if (r_state == S_RECV && w_end)
            r_mismatch <= (r_rx != w_expect);
      end
   end
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_hcnt    <= '0;
         r_bcnt    <= '0;
         r_sh      <= '0;
         r_rx      <= '0;
         r_product <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sclk    <= 1'b0;
         r_cs      <= 1'b0;
         r_mosi    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_next != r_state) begin
            r_hcnt <= '0;
            r_bcnt <= '0;
         end else if (w_active) begin
            r_hcnt <= w_tick ? '0 : r_hcnt + 1'b1;
            if (w_rise) r_bcnt <= r_bcnt + 1'b1;
         end
         if (w_active && w_tick) r_sclk <= !r_sclk;
         unique case (r_state)
            S_IDLE: begin
               if (START) begin
                  r_sh   <= {A[OP_WIDTH-2:0], B};
                  r_mosi <= A[OP_WIDTH-1];
                  r_rx   <= '0;
                  r_cs   <= 1'b1;
                  r_busy <= 1'b1;
                  r_sclk <= 1'b0;
               end
            end
            S_SEND: begin
               if (w_end) begin
                  r_mosi <= 1'b0;
               end else if (w_fall) begin
                  r_mosi <= r_sh[SW-1];
                  r_sh   <= {r_sh[SW-2:0], 1'b0};
               end
            end
            S_RECV: begin
               if (w_rise) r_rx <= {r_rx[RES_WIDTH-2:0], MISO};
               if (w_end) begin
                  r_cs      <= 1'b0;
                  r_done    <= 1'b1;
                  r_product <= r_rx;
               end
            end
            S_FIN:   r_busy <= 1'b0;
            default: ;
         endcase
      end
   end

   assign BUSY    = r_busy;
   assign DONE    = r_done;
   assign PRODUCT = r_product;
   assign SCLK    = r_sclk;
   assign CS      = r_cs;
   assign MOSI    = r_mosi;

endmodule

// File: tb/tb_spi_mult_master.sv
// Bench for spi_mult_master: behavioural SPI multiplier slave, scoreboard of
// expected products/latency, and a per-cycle pin monitor.
module tb_spi_mult_master;

   localparam int OPW = 4;
   localparam int RW  = 8;
   localparam int HP  = 10;
   localparam int TA  = 8;
   localparam int NR  = 2*OPW + TA + RW;
   localparam int LAT = 2*HP*NR;
   localparam int R0  = 2*OPW + TA + 1;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          START = 1'b0;
   logic [OPW-1:0] A = '0;
   logic [OPW-1:0] B = '0;
   logic          BUSY, DONE, SCLK, CS, MOSI, MISO;
   logic [RW-1:0] PRODUCT;
`ifdef SPI_MASTER_CHECK_EN
   logic          MISMATCH;
`endif

   spi_mult_master dut (
      .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
      .BUSY(BUSY), .DONE(DONE), .PRODUCT(PRODUCT),
      .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
`ifdef SPI_MASTER_CHECK_EN
      .MISMATCH(MISMATCH),
`endif
      .MISO(MISO)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d",
                  nm, act, req, cyc);
      end
   endtask

   // Behavioural slave: captures 2*OPW MOSI bits, returns the product MSB first
   bit            slave_en = 1'b1;
   int            rises = 0;
   logic [7:0]    cap = '0;
   logic [7:0]    sprod = '0;
   logic          smiso = 1'b0;

   always @(posedge CS) rises = 0;

   always @(posedge SCLK) begin
      rises++;
      if (rises <= 2*OPW) cap = {cap[6:0], MOSI};
      if (rises == 2*OPW) sprod = 8'(cap[7:4]) * 8'(cap[3:0]);
   end

   always @(negedge SCLK) begin
      int k;
      k = rises + 1;
      if (k >= R0 && k < R0 + RW) smiso = sprod[RW-1-(k-R0)];
      else smiso = 1'b0;
   end

   assign MISO = slave_en ? smiso : 1'b1;

   typedef struct {
      logic [7:0] prod;
      logic       mm;
      logic [7:0] bits;
      int         acc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] last_prod = '0;
   bit         after_done = 1'b0;

   always @(negedge CLK) begin
      exp_t e;
      if (!RST) begin
         if (DONE) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'(DONE), 32'd0);
            end else begin
               e = sb.pop_front();
               check("product", 32'(PRODUCT), 32'(e.prod));
               check("latency", 32'(cyc - e.acc), 32'(LAT));
               check("mosi_bits", 32'(cap), 32'(e.bits));
               check("sclk_rises", 32'(rises), 32'(NR));
               check("busy_in_fin", 32'(BUSY), 32'd1);
               check("cs_in_fin", 32'({CS, SCLK, MOSI}), 32'd0);
`ifdef SPI_MASTER_CHECK_EN
               check("mismatch", 32'(MISMATCH), 32'(e.mm));
`endif
               last_prod = e.prod;
            end
            after_done = 1'b1;
         end else begin
            if (after_done) check("busy_drop", 32'(BUSY), 32'd0);
            after_done = 1'b0;
            check("product_hold", 32'(PRODUCT), 32'(last_prod));
            if (BUSY) check("cs_high", 32'(CS), 32'd1);
            else check("idle_pins", 32'({CS, SCLK, MOSI}), 32'd0);
         end
      end
   end

   function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                  input int acc);
      exp_t e;
      logic [7:0] p;
      p = 8'(a) * 8'(b);
      e.prod = slave_en ? p : 8'hFF;
      e.mm   = (e.prod != p);
      e.bits = {a, b};
      e.acc  = acc;
      return e;
   endfunction

   task automatic go(input logic [3:0] a, input logic [3:0] b,
                     input bit hold);
      @(negedge CLK);
      A = a;
      B = b;
      START = 1'b1;
      @(posedge CLK);
      #1;
      check("accept_busy", 32'(BUSY), 32'd1);
      sb.push_back(model(a, b, cyc));
      if (!hold) START = 1'b0;
      A = 4'($urandom);
      B = 4'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || BUSY) && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      check("idle_timeout", 32'(n < 3000), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] a2, b2;
      int         acc1, n;
      repeat (3) @(negedge CLK);
      check("reset_pins", 32'({BUSY, DONE, SCLK, CS, MOSI}), 32'd0);
      check("reset_product", 32'(PRODUCT), 32'd0);
      RST = 1'b0;

      go(4'h1, 4'h6, 1'b0);
      wait_idle();
      go(4'hF, 4'hF, 1'b0);
      wait_idle();

      go(4'($urandom), 4'($urandom), 1'b0);
      repeat (100) @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check("busy_after_ignored_start", 32'(BUSY), 32'd1);
      wait_idle();

      go(4'hA, 4'h7, 1'b0);
      repeat (50) @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check("abort_pins", 32'({BUSY, DONE, SCLK, CS, MOSI}), 32'd0);
      check("abort_product", 32'(PRODUCT), 32'd0);
      last_prod = '0;
      sb.delete();
      RST = 1'b0;
      repeat (600) @(negedge CLK);
      go(4'h3, 4'h5, 1'b0);
      wait_idle();

      slave_en = 1'b0;
      go(4'h0, 4'h9, 1'b0);
      wait_idle();
      slave_en = 1'b1;
      go(4'h0, 4'h9, 1'b0);
      wait_idle();

      a2 = 4'($urandom);
      b2 = 4'($urandom);
      go(4'($urandom), 4'($urandom), 1'b1);
      acc1 = cyc;
      A = a2;
      B = b2;
      sb.push_back(model(a2, b2, acc1 + LAT + 2));
      n = 0;
      while (!(sb.size() == 1 && !BUSY) && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      check("b2b_first_timeout", 32'(n < 3000), 32'd1);
      @(posedge CLK);
      #1;
      check("b2b_accept", 32'(BUSY), 32'd1);
      START = 1'b0;
      wait_idle();

      repeat (5) begin
         repeat ($urandom_range(0, 5)) @(negedge CLK);
         go(4'($urandom), 4'($urandom), 1'b0);
         wait_idle();
      end
      repeat (5) @(negedge CLK);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
